// File: rtl/mmio_arbiter_pkg.sv
// Shared encodings and width defaults for the two-port mmio arbiter.
// Optional round-robin arbitration is enabled with MMIO_ARB_RR_EN.
`ifndef RegWidth
`define RegWidth 64
`endif
`ifndef WdtTypeCnt
`define WdtTypeCnt 4
`endif

package mmio_arbiter_pkg;

    localparam int ARB_REG_W = `RegWidth;
    localparam int ARB_OP_W  = `WdtTypeCnt;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_ACCESS = 2'd1,
        ARB_RESP   = 2'd2
    } arb_state_e;

    localparam logic ARB_OWN_IF = 1'b0;
    localparam logic ARB_OWN_LS = 1'b1;

endpackage

// File: rtl/mmio_arb_pick.sv
// Combinational grant logic: one-hot grant, bit 0 = fetch, bit 1 = load/store.
// With MMIO_ARB_RR_EN the port not granted last wins a conflict, else LSU wins.
module mmio_arb_pick
    import mmio_arbiter_pkg::*;
(
    input  logic       if_valid,
    input  logic       ls_valid,
`ifdef MMIO_ARB_RR_EN
    input  logic       last_owner,
`endif
    output logic [1:0] grant
);

    // Resolve the grant among the two requesters.
    always_comb begin
        grant = 2'b00;
        if (if_valid && ls_valid) begin
`ifdef MMIO_ARB_RR_EN
            grant = (last_owner == ARB_OWN_LS) ? 2'b01 : 2'b10;
`else
            grant = 2'b10;
`endif
        end else if (ls_valid) begin
            grant = 2'b10;
        end else if (if_valid) begin
            grant = 2'b01;
        end else begin
            grant = 2'b00;
        end
    end

endmodule

// File: rtl/mmio_arbiter.sv
// Two-port arbiter/sequencer for the shared mmio port: one access per accepted
// request, registered response. Round-robin arbitration under MMIO_ARB_RR_EN.
module mmio_arbiter
    import mmio_arbiter_pkg::*;
#(
    parameter int ADDR_W = ARB_REG_W,
    parameter int DATA_W = ARB_REG_W,
    parameter int OP_W   = ARB_OP_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_valid,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ready,
    output logic              if_resp_valid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              ls_valid,
    input  logic              ls_wen,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [DATA_W-1:0] ls_wdata,
    input  logic [OP_W-1:0]   ls_op,
    output logic              ls_ready,
    output logic              ls_resp_valid,
    output logic [DATA_W-1:0] ls_rdata,
    output logic [ADDR_W-1:0] mem_raddr,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_ren,
    output logic              mem_wen,
    output logic [OP_W-1:0]   wdt_op,
    input  logic [DATA_W-1:0] mem_rdata
);

    arb_state_e        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [OP_W-1:0]   op_q, op_d;
    logic              wen_q, wen_d;
    logic              owner_q, owner_d;
    logic              if_resp_q, if_resp_d;
    logic              ls_resp_q, ls_resp_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] ls_rdata_q, ls_rdata_d;
    logic [1:0]        grant_s;
    logic              can_accept_s;
    logic              accept_s;
    logic              in_access_s;

`ifdef MMIO_ARB_RR_EN
    logic              last_q, last_d;
`endif

    mmio_arb_pick u_pick (
        .if_valid   (if_valid),
        .ls_valid   (ls_valid),
`ifdef MMIO_ARB_RR_EN
        .last_owner (last_q),
`endif
        .grant      (grant_s)
    );

    // Acceptance window: a new request may be taken in IDLE or overlapping RESP.
    always_comb begin
        can_accept_s = (state_q == ARB_IDLE) || (state_q == ARB_RESP);
        accept_s     = can_accept_s && (grant_s != 2'b00);
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ARB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ARB_IDLE, ARB_RESP: state_d = accept_s ? ARB_ACCESS : ARB_IDLE;
            ARB_ACCESS:         state_d = ARB_RESP;
            default:            state_d = ARB_IDLE;
        endcase
    end

    // FSM outputs; mem_* derive from state so reset kills enables at once.
    always_comb begin
        in_access_s   = (state_q == ARB_ACCESS);
        if_ready      = can_accept_s && grant_s[0];
        ls_ready      = can_accept_s && grant_s[1];
        mem_raddr     = in_access_s ? addr_q  : {ADDR_W{1'b0}};
        mem_waddr     = in_access_s ? addr_q  : {ADDR_W{1'b0}};
        mem_wdata     = in_access_s ? wdata_q : {DATA_W{1'b0}};
        wdt_op        = in_access_s ? op_q    : {OP_W{1'b0}};
        mem_ren       = in_access_s && !wen_q;
        mem_wen       = in_access_s && wen_q;
        if_resp_valid = if_resp_q;
        ls_resp_valid = ls_resp_q;
        if_rdata      = if_rdata_q;
        ls_rdata      = ls_rdata_q;
    end

    // Request latch on accept and response capture during ACCESS.
    always_comb begin
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        op_d       = op_q;
        wen_d      = wen_q;
        owner_d    = owner_q;
        if_resp_d  = 1'b0;
        ls_resp_d  = 1'b0;
        if_rdata_d = if_rdata_q;
        ls_rdata_d = ls_rdata_q;
        if (accept_s) begin
            if (grant_s[1]) begin
                owner_d = ARB_OWN_LS;
                addr_d  = ls_addr;
                wdata_d = ls_wdata;
                op_d    = ls_op;
                wen_d   = ls_wen;
            end else begin
                owner_d = ARB_OWN_IF;
                addr_d  = if_addr;
                wdata_d = {DATA_W{1'b0}};
                op_d    = {OP_W{1'b0}};
                wen_d   = 1'b0;
            end
        end else begin
            owner_d = owner_q;
        end
        if (state_q == ARB_ACCESS) begin
            if (owner_q == ARB_OWN_LS) begin
                ls_resp_d  = 1'b1;
                ls_rdata_d = wen_q ? {DATA_W{1'b0}} : mem_rdata;
            end else begin
                if_resp_d  = 1'b1;
                if_rdata_d = mem_rdata;
            end
        end else begin
            if_resp_d = 1'b0;
            ls_resp_d = 1'b0;
        end
    end

`ifdef MMIO_ARB_RR_EN
    // Remember which port was granted last; reset favours fetch on first conflict.
    always_comb begin
        if (accept_s) begin
            last_d = grant_s[1];
        end else begin
            last_d = last_q;
        end
    end

    // Round-robin pointer register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= ARB_OWN_LS;
        end else begin
            last_q <= last_d;
        end
    end
`endif

    // Datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q     <= {ADDR_W{1'b0}};
            wdata_q    <= {DATA_W{1'b0}};
            op_q       <= {OP_W{1'b0}};
            wen_q      <= 1'b0;
            owner_q    <= ARB_OWN_IF;
            if_resp_q  <= 1'b0;
            ls_resp_q  <= 1'b0;
            if_rdata_q <= {DATA_W{1'b0}};
            ls_rdata_q <= {DATA_W{1'b0}};
        end else begin
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            op_q       <= op_d;
            wen_q      <= wen_d;
            owner_q    <= owner_d;
            if_resp_q  <= if_resp_d;
            ls_resp_q  <= ls_resp_d;
            if_rdata_q <= if_rdata_d;
            ls_rdata_q <= ls_rdata_d;
        end
    end

endmodule

// File: tb/tb_mmio_arbiter.sv
// Directed + randomized bench for mmio_arbiter; mmio read data comes from a
// fixed address hash so expected responses follow directly from the address.
module tb_mmio_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_valid, if_ready, if_resp_valid;
    logic [63:0] if_addr, if_rdata;
    logic        ls_valid, ls_wen, ls_ready, ls_resp_valid;
    logic [63:0] ls_addr, ls_wdata, ls_rdata;
    logic [3:0]  ls_op, wdt_op;
    logic [63:0] mem_raddr, mem_waddr, mem_wdata, mem_rdata;
    logic        mem_ren, mem_wen;

    int errors = 0;
    int checks = 0;
    bit last_ls = 1'b1;
    logic [63:0] exp_if_rdata = 64'h0;
    logic [63:0] exp_ls_rdata = 64'h0;

    mmio_arbiter dut (
        .clk(clk), .rst(rst),
        .if_valid(if_valid), .if_addr(if_addr), .if_ready(if_ready),
        .if_resp_valid(if_resp_valid), .if_rdata(if_rdata),
        .ls_valid(ls_valid), .ls_wen(ls_wen), .ls_addr(ls_addr),
        .ls_wdata(ls_wdata), .ls_op(ls_op), .ls_ready(ls_ready),
        .ls_resp_valid(ls_resp_valid), .ls_rdata(ls_rdata),
        .mem_raddr(mem_raddr), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .mem_ren(mem_ren), .mem_wen(mem_wen), .wdt_op(wdt_op),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] mmio_fn(input logic [63:0] a);
        return {a[31:0] ^ 32'hDEAD_BEEF, a[63:32] + 32'h1357_9BDF};
    endfunction

    assign mem_rdata = mmio_fn(mem_raddr);

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic scramble_payload();
        if_addr  = {$urandom, $urandom};
        ls_addr  = {$urandom, $urandom};
        ls_wdata = {$urandom, $urandom};
        ls_op    = 4'($urandom_range(15, 0));
        ls_wen   = 1'($urandom_range(1, 0));
    endtask

    // One isolated transaction from IDLE: accept, access, response, hold.
    task automatic single(input bit is_ls, input bit wen, input logic [63:0] addr,
                          input logic [63:0] wdata, input logic [3:0] op);
        bit store;
        store = is_ls && wen;
        if (is_ls) begin
            ls_valid = 1'b1; ls_wen = wen; ls_addr = addr; ls_wdata = wdata; ls_op = op;
        end else begin
            if_valid = 1'b1; if_addr = addr;
        end
        @(negedge clk);
        chk("acc_if_ready", if_ready, 64'(!is_ls));
        chk("acc_ls_ready", ls_ready, 64'(is_ls));
        chk("acc_no_ren", mem_ren, 64'h0);
        chk("acc_no_wen", mem_wen, 64'h0);
        next_cycle();
        if_valid = 1'b0; ls_valid = 1'b0; last_ls = is_ls;
        scramble_payload();
        @(negedge clk);
        chk("mem_ren", mem_ren, 64'(!store));
        chk("mem_wen", mem_wen, 64'(store));
        chk("mem_raddr", mem_raddr, addr);
        chk("mem_waddr", mem_waddr, addr);
        chk("access_if_ready", if_ready, 64'h0);
        chk("access_ls_ready", ls_ready, 64'h0);
        if (store) begin
            chk("mem_wdata", mem_wdata, wdata);
            chk("wdt_op", wdt_op, 64'(op));
        end
        next_cycle();
        @(negedge clk);
        chk("resp_if_valid", if_resp_valid, 64'(!is_ls));
        chk("resp_ls_valid", ls_resp_valid, 64'(is_ls));
        chk("resp_ren_low", mem_ren, 64'h0);
        chk("resp_wen_low", mem_wen, 64'h0);
        chk("resp_raddr_zero", mem_raddr, 64'h0);
        if (is_ls) begin
            exp_ls_rdata = store ? 64'h0 : mmio_fn(addr);
            chk("ls_rdata", ls_rdata, exp_ls_rdata);
        end else begin
            exp_if_rdata = mmio_fn(addr);
            chk("if_rdata", if_rdata, exp_if_rdata);
        end
        next_cycle();
        @(negedge clk);
        chk("after_if_valid", if_resp_valid, 64'h0);
        chk("after_ls_valid", ls_resp_valid, 64'h0);
        chk("hold_if_rdata", if_rdata, exp_if_rdata);
        chk("hold_ls_rdata", ls_rdata, exp_ls_rdata);
        next_cycle();
    endtask

    // Both ports request loads in the same cycle.
    task automatic conflict(input logic [63:0] ia, input logic [63:0] la);
        bit ls_first;
        logic [63:0] wa, lsa;
`ifdef MMIO_ARB_RR_EN
        ls_first = !last_ls;
`else
        ls_first = 1'b1;
`endif
        wa  = ls_first ? la : ia;
        lsa = ls_first ? ia : la;
        if_valid = 1'b1; if_addr = ia;
        ls_valid = 1'b1; ls_wen = 1'b0; ls_addr = la;
        @(negedge clk);
        chk("cf_if_ready0", if_ready, 64'(!ls_first));
        chk("cf_ls_ready0", ls_ready, 64'(ls_first));
        next_cycle();
        if (ls_first) ls_valid = 1'b0; else if_valid = 1'b0;
        last_ls = ls_first;
        @(negedge clk);
        chk("cf_ren1", mem_ren, 64'h1);
        chk("cf_raddr1", mem_raddr, wa);
        chk("cf_ready1", 64'({if_ready, ls_ready}), 64'h0);
        next_cycle();
        @(negedge clk);
        chk("cf_win_resp", ls_first ? ls_resp_valid : if_resp_valid, 64'h1);
        chk("cf_win_data", ls_first ? ls_rdata : if_rdata, mmio_fn(wa));
        chk("cf_lose_ready", ls_first ? if_ready : ls_ready, 64'h1);
        chk("cf_win_ready", ls_first ? ls_ready : if_ready, 64'h0);
        if (ls_first) exp_ls_rdata = mmio_fn(wa); else exp_if_rdata = mmio_fn(wa);
        next_cycle();
        if_valid = 1'b0; ls_valid = 1'b0;
        last_ls = !ls_first;
        @(negedge clk);
        chk("cf_raddr3", mem_raddr, lsa);
        chk("cf_ren3", mem_ren, 64'h1);
        chk("cf_resp3", 64'({if_resp_valid, ls_resp_valid}), 64'h0);
        next_cycle();
        @(negedge clk);
        chk("cf_lose_resp", ls_first ? if_resp_valid : ls_resp_valid, 64'h1);
        chk("cf_lose_data", ls_first ? if_rdata : ls_rdata, mmio_fn(lsa));
        chk("cf_win_quiet", ls_first ? ls_resp_valid : if_resp_valid, 64'h0);
        if (ls_first) exp_if_rdata = mmio_fn(lsa); else exp_ls_rdata = mmio_fn(lsa);
        next_cycle();
        next_cycle();
    endtask

    initial begin
        logic [63:0] a [3];
        int ren_cnt;
        rst = 1'b1;
        if_valid = 1'b0; if_addr = 64'h0;
        ls_valid = 1'b0; ls_wen = 1'b0; ls_addr = 64'h0; ls_wdata = 64'h0; ls_op = 4'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_mem_ren", mem_ren, 64'h0);
        chk("rst_mem_wen", mem_wen, 64'h0);
        chk("rst_mem_raddr", mem_raddr, 64'h0);
        chk("rst_mem_wdata", mem_wdata, 64'h0);
        chk("rst_wdt_op", wdt_op, 64'h0);
        chk("rst_resp", 64'({if_resp_valid, ls_resp_valid}), 64'h0);
        chk("rst_if_rdata", if_rdata, 64'h0);
        chk("rst_ls_rdata", ls_rdata, 64'h0);
        next_cycle();
        rst = 1'b0;
        next_cycle();

        single(1'b0, 1'b0, 64'h0000_0000_8000_0000, 64'h0, 4'h0);
        single(1'b1, 1'b1, 64'h0000_0000_A000_0100, 64'h0000_0000_0000_1234, 4'h2);
        conflict(64'h0000_0000_8000_0040, 64'h0000_0000_A000_0200);
        conflict({$urandom, $urandom}, {$urandom, $urandom});

        // Keyboard read: exactly one read pulse.
        ren_cnt = 0;
        ls_valid = 1'b1; ls_wen = 1'b0; ls_addr = 64'h0000_0000_A000_0008;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (mem_ren) ren_cnt++;
            next_cycle();
            if (i == 0) begin ls_valid = 1'b0; last_ls = 1'b1; end
        end
        exp_ls_rdata = mmio_fn(64'h0000_0000_A000_0008);
        chk("kb_ren_pulses", 64'(ren_cnt), 64'h1);

        // Back-to-back loads held valid for six cycles.
        for (int k = 0; k < 3; k++) a[k] = {$urandom, $urandom};
        ls_valid = 1'b1; ls_wen = 1'b0; ls_addr = a[0];
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("b2b_ready", ls_ready, 64'h1);
            chk("b2b_idle_ren", mem_ren, 64'h0);
            if (k > 0) begin
                chk("b2b_resp", ls_resp_valid, 64'h1);
                chk("b2b_rdata", ls_rdata, mmio_fn(a[k-1]));
            end
            next_cycle();
            if (k < 2) ls_addr = a[k+1];
            last_ls = 1'b1;
            @(negedge clk);
            chk("b2b_access_ready", ls_ready, 64'h0);
            chk("b2b_ren", mem_ren, 64'h1);
            chk("b2b_raddr", mem_raddr, a[k]);
            next_cycle();
            if (k == 2) ls_valid = 1'b0;
        end
        @(negedge clk);
        chk("b2b_last_resp", ls_resp_valid, 64'h1);
        chk("b2b_last_rdata", ls_rdata, mmio_fn(a[2]));
        chk("b2b_last_ready", ls_ready, 64'h0);
        exp_ls_rdata = mmio_fn(a[2]);
        next_cycle();
        next_cycle();

        // Randomized isolated transactions.
        for (int n = 0; n < 10; n++) begin
            single(1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), {$urandom, $urandom},
                   {$urandom, $urandom}, 4'($urandom_range(15, 0)));
        end

        // Reset during the ACCESS cycle of a store.
        ls_valid = 1'b1; ls_wen = 1'b1; ls_addr = 64'h0000_0000_A000_0010;
        ls_wdata = 64'h55; ls_op = 4'h1;
        @(negedge clk);
        chk("rst_mid_accept", ls_ready, 64'h1);
        next_cycle();
        ls_valid = 1'b0;
        @(negedge clk);
        chk("rst_mid_wen_before", mem_wen, 64'h1);
        #1 rst = 1'b1;
        #1;
        chk("rst_mid_wen_drop", mem_wen, 64'h0);
        chk("rst_mid_ren_drop", mem_ren, 64'h0);
        next_cycle();
        rst = 1'b0;
        last_ls = 1'b1;
        exp_if_rdata = 64'h0;
        exp_ls_rdata = 64'h0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_mid_no_resp", ls_resp_valid, 64'h0);
            chk("rst_mid_no_wen", mem_wen, 64'h0);
            next_cycle();
        end
        single(1'b0, 1'b0, 64'h0000_0000_8000_0100, 64'h0, 4'h0);
        conflict({$urandom, $urandom}, {$urandom, $urandom});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mmio_arbiter.md
# mmio_arbiter

Two-port arbiter and access sequencer in front of the single `mmio` port. Shares the port between the instruction-fetch unit (port 0, read-only) and the load/store unit (port 1, read/write). Each accepted request becomes exactly one mmio access cycle, and the result is returned as a registered response. Guarantees single-cycle `mem_ren`/`mem_wen` pulses, because mmio reads have side effects (keyboard pop via `sig_rd_kb`).

## Interface
Parameters:
- `ADDR_W`, 64, request/mmio address width
- `DATA_W`, 64, write/read data width
- `OP_W`, 4, width of the write-type/size code (`wdt_op`)

Ports:
- `clk`  in  1  clock; all state on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `if_valid`  in  1  fetch request valid
- `if_addr`  in  ADDR_W  fetch address
- `if_ready`  out  1  fetch request accepted this cycle
- `if_resp_valid`  out  1  fetch data valid, one-cycle pulse
- `if_rdata`  out  DATA_W  fetch read data
- `ls_valid`  in  1  load/store request valid
- `ls_wen`  in  1  1 = store, 0 = load
- `ls_addr`  in  ADDR_W  load/store address
- `ls_wdata`  in  DATA_W  store data
- `ls_op`  in  OP_W  store width code, passed to `wdt_op`
- `ls_ready`  out  1  load/store accepted this cycle
- `ls_resp_valid`  out  1  load data / store done, one-cycle pulse
- `ls_rdata`  out  DATA_W  load data; 0 for stores
- `mem_raddr`  out  ADDR_W  to mmio read address
- `mem_waddr`  out  ADDR_W  to mmio write address
- `mem_wdata`  out  DATA_W  to mmio write data
- `mem_ren`  out  1  to mmio read enable
- `mem_wen`  out  1  to mmio write enable
- `wdt_op`  out  OP_W  to mmio write type
- `mem_rdata`  in  DATA_W  from mmio, combinational read data

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE, or RESP with a new request pending: arbitrate, assert that port's `*_ready` combinationally, latch address/data/op/owner and go to ACCESS. With no request, RESP goes to IDLE.
- ACCESS: drive `mem_*` from the latched registers. Assert exactly one of `mem_ren`/`mem_wen`; the fetch port is always a read. Capture `mem_rdata` into a response register. Next state is RESP.
- RESP: pulse the owner's `*_resp_valid` for one cycle. The non-owner's response stays 0.
- Ready is never asserted in ACCESS.
- Arbitration when both ports are valid: fixed priority, LSU wins. Fetch waits with `if_valid` held high.
- Requesters hold valid and payload stable until ready. After acceptance, the payload is don't-care.
- Store response: `ls_rdata` = 0. The `mem_wen` pulse lasts exactly one cycle (mmio commits on the falling edge inside it).
- `mem_raddr` and `mem_waddr` are both driven with the latched address in ACCESS. All `mem_*` outputs are 0 outside ACCESS.

## Timing
- Reset values: state IDLE; all outputs 0; latched regs 0; RR pointer = LSU-last.
- Latency: request accepted in cycle N, mmio access in N+1, response in N+2.
- Throughput: one access per 2 cycles when back-to-back (accept overlaps RESP).
- Simultaneous response and new accept in RESP is legal. A port may be accepted in the same cycle its own previous response is asserted.
- Reset mid-operation (ACCESS or RESP): the transaction is aborted. `mem_wen`/`mem_ren` drop immediately (asynchronously) and no response is issued.
- `rdata` holds its last value between responses and is valid only with `*_resp_valid`.

## Configuration
- `MMIO_ARB_RR_EN`
  - Defined: round-robin on conflict. The port not granted last wins. The pointer updates on every accept. After reset the fetch port wins the first conflict.
  - Undefined: fixed LSU priority. The pointer logic is absent.

## Structure
- The shared package/defines file holds:
  - FSM state encoding `ARB_IDLE/ARB_ACCESS/ARB_RESP` (2 bits).
  - Owner encoding `ARB_OWN_IF=0`, `ARB_OWN_LS=1`.
  - The existing `RegWidth`/`WdtTypeCnt` width macros used as parameter defaults.
- Sub-module `mmio_arb_pick` is natural: it is the combinational grant logic taking both valids and the RR pointer and producing the one-hot grant.
- The FSM and registers stay in `mmio_arbiter`.

## Test plan
- Single fetch: `if_addr`=0x8000_0000 in cycle 0 → `if_ready`=1 in cycle 0; `mem_ren`=1 and `mem_raddr`=0x8000_0000 in cycle 1 only; `if_resp_valid`=1 with the mmio data in cycle 2.
- Store: `ls_wen`=1, addr=SEG address, wdata=0x1234, op=2 → one cycle with `mem_wen`=1, `mem_wdata`=0x1234, `wdt_op`=2; `ls_resp_valid`, `ls_rdata`=0 one cycle later; `mem_ren` never 1.
- Conflict: both valid in cycle 0 → fixed priority: LS granted, IF granted in cycle 2 (RESP), IF response in cycle 4. With `MMIO_ARB_RR_EN`: IF granted first, LS second.
- Keyboard read: one load from the keyboard address → `mem_ren` high exactly 1 cycle (a single `sig_rd_kb` pop).
- Back-to-back loads held valid for 6 cycles → accepts in cycles 0/2/4; `mem_ren` in 1/3/5; `ready` never high in ACCESS.
- `rst` asserted in the middle of the ACCESS cycle of a store → `mem_wen` falls immediately; no `ls_resp_valid`; state IDLE after release.
